// File: rtl/soc_decode_wb_pkg.sv
// Shared types and decode helpers for the registered Wishbone address decoder.
// Address windows are compared at up to MAX_AW bits, and at most MAX_SLAVES ports are supported.
package soc_decode_wb_pkg;

  localparam int unsigned MAX_SLAVES = 16;
  localparam int unsigned MAX_AW     = 64;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR,
    TMO
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Grant index width: $clog2(n), never below 1
  function automatic int unsigned gnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic win_hit(input logic [MAX_AW-1:0] adr,
                                   input logic [MAX_AW-1:0] base,
                                   input logic [MAX_AW-1:0] mask,
                                   input logic              en);
    return en && ((adr & mask) == (base & mask));
  endfunction

  // Lowest set index wins; scanning downwards leaves the lowest match last
  function automatic dec_t prio_decode(input logic [MAX_SLAVES-1:0] match);
    dec_t d;
    d = '0;
    for (int unsigned i = MAX_SLAVES; i > 0; i--) begin
      if (match[i-1]) begin
        d.hit = 1'b1;
        d.idx = IDX_W'(i-1);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/soc_decode_wb_reg_if.sv
// Wishbone bundle for the decoder: one master request/response and SLAVES slave lanes.
// "master" is the bus master's view, "slave" is the decoder's view, and "periph" is the view of the slave devices.
interface soc_decode_wb_reg_if #(
  parameter int unsigned SLAVES     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] m_adr_i;
  logic [DATA_WIDTH-1:0] m_dat_i;
  logic                  m_cyc_i;
  logic                  m_stb_i;
  logic [SEL_WIDTH-1:0]  m_sel_i;
  logic                  m_we_i;
  logic [2:0]            m_cti_i;
  logic [1:0]            m_bte_i;

  logic [DATA_WIDTH-1:0] m_dat_o;
  logic                  m_ack_o;
  logic                  m_err_o;
  logic                  m_rty_o;

  logic [SLAVES-1:0][ADDR_WIDTH-1:0] s_adr_o;
  logic [SLAVES-1:0][DATA_WIDTH-1:0] s_dat_o;
  logic [SLAVES-1:0]                 s_cyc_o;
  logic [SLAVES-1:0]                 s_stb_o;
  logic [SLAVES-1:0][SEL_WIDTH-1:0]  s_sel_o;
  logic [SLAVES-1:0]                 s_we_o;
  logic [SLAVES-1:0][2:0]            s_cti_o;
  logic [SLAVES-1:0][1:0]            s_bte_o;

  logic [SLAVES-1:0][DATA_WIDTH-1:0] s_dat_i;
  logic [SLAVES-1:0]                 s_ack_i;
  logic [SLAVES-1:0]                 s_err_i;
  logic [SLAVES-1:0]                 s_rty_i;

  modport master (
    output m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_sel_i, m_we_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o
  );

  modport slave (
    input  m_adr_i, m_dat_i, m_cyc_i, m_stb_i, m_sel_i, m_we_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_sel_o, s_we_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport periph (
    input  s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_sel_o, s_we_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/soc_decode_wb_watchdog.sv
// Slave watchdog: counts strobed cycles without a response and flags the terminal cycle.
module soc_decode_wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_resp,
  output logic o_tc
);
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !i_active || i_resp) begin
      r_cnt <= '0;
    end else if (i_stb && r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A response on the limit cycle masks the timeout
  assign o_tc = i_active & i_stb & ~i_resp & (r_cnt == LIMIT);

endmodule

// File: rtl/soc_decode_wb_reg.sv
// Registered, grant-locked Wishbone address decoder with an unmapped-address error responder and sticky error capture.
// Define SOC_DECODE_WB_TIMEOUT_EN to add the slave watchdog and TMO state. Address windows support up to 64 address bits.
module soc_decode_wb_reg
  import soc_decode_wb_pkg::*;
#(
  parameter int unsigned                     SLAVES         = 4,
  parameter int unsigned                     DATA_WIDTH     = 32,
  parameter int unsigned                     ADDR_WIDTH     = 32,
  parameter logic [SLAVES-1:0]               SLAVE_ENABLE   = {SLAVES{1'b1}},
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE   = '0,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_MASK   = '0,
  parameter int unsigned                     TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  soc_decode_wb_reg_if.slave    bus,
  output logic                  err_valid_o,
  output logic [ADDR_WIDTH-1:0] err_adr_o,
  output logic                  err_timeout_o,
  input  logic                  err_clr_i
);
  localparam int unsigned GNT_W = gnt_width(SLAVES);

  state_t                  r_state, w_next;
  logic [GNT_W-1:0]        r_gnt;
  logic [MAX_SLAVES-1:0]   w_match;
  dec_t                    w_dec;
  logic                    w_req, w_resp, w_tmo, w_active;
  logic                    w_err_enter, w_tmo_enter, w_new_err;
  logic [SLAVES-1:0]       w_s_cyc, w_s_stb;
  logic [DATA_WIDTH-1:0]   w_m_dat;
  logic                    w_m_ack, w_m_err, w_m_rty;
  logic                    r_err_valid;
  logic [ADDR_WIDTH-1:0]   r_err_adr;

  assign bus.s_adr_o = {SLAVES{bus.m_adr_i}};
  assign bus.s_dat_o = {SLAVES{bus.m_dat_i}};
  assign bus.s_sel_o = {SLAVES{bus.m_sel_i}};
  assign bus.s_we_o  = {SLAVES{bus.m_we_i}};
  assign bus.s_cti_o = {SLAVES{bus.m_cti_i}};
  assign bus.s_bte_o = {SLAVES{bus.m_bte_i}};

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      w_match[i] = win_hit(MAX_AW'(bus.m_adr_i), MAX_AW'(SLAVE_BASE[i]),
                           MAX_AW'(SLAVE_MASK[i]), SLAVE_ENABLE[i]);
    end
  end

  assign w_dec    = prio_decode(w_match);
  assign w_req    = bus.m_cyc_i & bus.m_stb_i;
  assign w_active = (r_state == ACTIVE);
  assign w_resp   = bus.s_ack_i[r_gnt] | bus.s_err_i[r_gnt] | bus.s_rty_i[r_gnt];

`ifdef SOC_DECODE_WB_TIMEOUT_EN
  soc_decode_wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_active (w_active),
    .i_stb    (w_s_stb[r_gnt]),
    .i_resp   (w_resp),
    .o_tc     (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_gnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req && w_dec.hit) begin
        r_gnt <= w_dec.idx[GNT_W-1:0];
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_s_cyc = '0;
    w_s_stb = '0;
    w_m_dat = '0;
    w_m_ack = 1'b0;
    w_m_err = 1'b0;
    w_m_rty = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) w_next = w_dec.hit ? ACTIVE : ERR;
      end
      ACTIVE: begin
        w_s_cyc[r_gnt] = bus.m_cyc_i;
        w_s_stb[r_gnt] = bus.m_stb_i;
        w_m_dat        = bus.s_dat_i[r_gnt];
        w_m_ack        = bus.s_ack_i[r_gnt];
        w_m_err        = bus.s_err_i[r_gnt];
        w_m_rty        = bus.s_rty_i[r_gnt];
        if (!bus.m_cyc_i)  w_next = IDLE;
        else if (w_tmo)    w_next = TMO;
      end
      ERR, TMO: begin
        w_m_err = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.s_cyc_o = w_s_cyc;
  assign bus.s_stb_o = w_s_stb;
  assign bus.m_dat_o = w_m_dat;
  assign bus.m_ack_o = w_m_ack;
  assign bus.m_err_o = w_m_err;
  assign bus.m_rty_o = w_m_rty;

  assign w_err_enter = (r_state == IDLE) & w_req & ~w_dec.hit;
  assign w_tmo_enter = w_active & bus.m_cyc_i & w_tmo;
  assign w_new_err   = w_err_enter | w_tmo_enter;

  // A clear coinciding with a new error lets the new error be captured
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_valid <= 1'b0;
      r_err_adr   <= '0;
    end else if (w_new_err && (!r_err_valid || err_clr_i)) begin
      r_err_valid <= 1'b1;
      r_err_adr   <= bus.m_adr_i;
    end else if (err_clr_i) begin
      r_err_valid <= 1'b0;
      r_err_adr   <= '0;
    end
  end

`ifdef SOC_DECODE_WB_TIMEOUT_EN
  logic r_err_tmo;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_tmo <= 1'b0;
    end else if (w_new_err && (!r_err_valid || err_clr_i)) begin
      r_err_tmo <= w_tmo_enter;
    end else if (err_clr_i) begin
      r_err_tmo <= 1'b0;
    end
  end
  assign err_timeout_o = r_err_tmo;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign err_valid_o = r_err_valid;
  assign err_adr_o   = r_err_adr;

endmodule

// File: tb/tb_soc_decode_wb_reg.sv
// Directed bench for soc_decode_wb_reg: decode, error capture, priority, locked bursts, watchdog and reset.
module tb_soc_decode_wb_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_valid, err_tmo;
  logic [31:0] err_adr;
  int          total = 0;
  int          bad = 0;
  int          pulses;

  always #5 clk = ~clk;

  soc_decode_wb_reg_if #(.SLAVES(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  soc_decode_wb_reg #(
    .SLAVES        (4),
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .SLAVE_ENABLE  (4'b0111),
    .SLAVE_BASE    ({32'h4000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000}),
    .SLAVE_MASK    ({32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hFFFF_F000}),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .err_valid_o  (err_valid),
    .err_adr_o    (err_adr),
    .err_timeout_o(err_tmo),
    .err_clr_i    (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [2:0] cti);
    bus.m_adr_i = adr;
    bus.m_we_i  = we;
    bus.m_cti_i = cti;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
  endtask

  task automatic drop();
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.s_ack_i = '0;
    bus.s_err_i = '0;
    bus.s_rty_i = '0;
  endtask

  initial begin
    bus.m_adr_i = '0;
    bus.m_dat_i = 32'h1234_5678;
    bus.m_sel_i = 4'hF;
    bus.m_bte_i = 2'b00;
    bus.m_we_i  = 1'b0;
    bus.m_cti_i = 3'b000;
    bus.s_dat_i = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_AAAA};
    drop();

    // Reset state
    tick(); tick(); settle();
    chk("rst_s_cyc", bus.s_cyc_o, 4'b0000);
    chk("rst_s_stb", bus.s_stb_o, 4'b0000);
    chk("rst_m_ack", bus.m_ack_o, 1'b0);
    chk("rst_m_err", bus.m_err_o, 1'b0);
    chk("rst_m_rty", bus.m_rty_o, 1'b0);
    chk("rst_m_dat", bus.m_dat_o, 32'h0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_err_adr", err_adr, 32'h0);
    chk("rst_err_tmo", err_tmo, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic read from slave 2
    req(32'h2000_0010, 1'b0, 3'b000);
    settle();
    chk("rd_decode_latency", bus.s_cyc_o, 4'b0000);
    tick(); settle();
    chk("rd_s_cyc", bus.s_cyc_o, 4'b0100);
    chk("rd_s_stb", bus.s_stb_o, 4'b0100);
    chk("rd_s_adr_bcast", bus.s_adr_o[0], 32'h2000_0010);
    chk("rd_no_ack_yet", bus.m_ack_o, 1'b0);
    bus.s_ack_i[2] = 1'b1;
    settle();
    chk("rd_m_ack", bus.m_ack_o, 1'b1);
    chk("rd_m_dat", bus.m_dat_o, 32'hDEAD_BEEF);
    tick();
    drop();
    settle();
    chk("rd_cyc_fall", bus.s_cyc_o, 4'b0000);
    tick();

    // Unmapped write
    req(32'h9000_0000, 1'b1, 3'b000);
    settle();
    chk("um_idle_no_err", bus.m_err_o, 1'b0);
    tick(); settle();
    chk("um_m_err", bus.m_err_o, 1'b1);
    chk("um_m_ack", bus.m_ack_o, 1'b0);
    chk("um_s_cyc", bus.s_cyc_o, 4'b0000);
    chk("um_err_valid", err_valid, 1'b1);
    chk("um_err_adr", err_adr, 32'h9000_0000);
    chk("um_err_tmo", err_tmo, 1'b0);
    drop();
    tick(); settle();
    chk("um_pulse_end", bus.m_err_o, 1'b0);

    // Disabled slave 3 behaves as unmapped; capture is sticky
    req(32'h4000_0000, 1'b0, 3'b000);
    tick(); settle();
    chk("dis_m_err", bus.m_err_o, 1'b1);
    chk("dis_s_cyc", bus.s_cyc_o, 4'b0000);
    chk("sticky_adr", err_adr, 32'h9000_0000);
    drop();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    chk("clr_valid", err_valid, 1'b0);

    // Clear and new error in the same cycle: new error captured
    req(32'h9000_0004, 1'b0, 3'b000);
    tick();
    drop();
    tick();
    req(32'hA000_0000, 1'b0, 3'b000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    chk("clr_vs_new_valid", err_valid, 1'b1);
    chk("clr_vs_new_adr", err_adr, 32'hA000_0000);

    // Held strobe at an unmapped address: one err pulse per two cycles
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      if (bus.m_err_o === 1'b1) pulses++;
    end
    chk("err_pulse_rate", 64'(pulses), 64'd2);
    drop();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Overlap: slaves 0 and 1 both match, slave 0 wins
    req(32'h0000_0100, 1'b1, 3'b000);
    tick(); settle();
    chk("ovl_s_cyc", bus.s_cyc_o, 4'b0001);
    chk("ovl_no_err", bus.m_err_o, 1'b0);
    chk("ovl_s_dat", bus.s_dat_o[0], 32'h1234_5678);
    chk("ovl_s_we", bus.s_we_o, 4'b1111);
    bus.s_rty_i[0] = 1'b1;
    settle();
    chk("ovl_m_rty", bus.m_rty_o, 1'b1);
    chk("ovl_m_dat", bus.m_dat_o, 32'h0000_AAAA);
    drop();
    tick(); tick();

    // Locked 4-beat incrementing burst crossing into slave 2's window
    req(32'h1FFF_FFF8, 1'b0, 3'b010);
    tick();
    for (int b = 0; b < 4; b++) begin
      bus.m_adr_i = 32'h1FFF_FFF8 + 32'(4 * b);
      bus.m_cti_i = (b == 3) ? 3'b111 : 3'b010;
      bus.s_ack_i[1] = 1'b1;
      settle();
      chk($sformatf("bst_s_cyc_%0d", b), bus.s_cyc_o, 4'b0010);
      chk($sformatf("bst_m_dat_%0d", b), bus.m_dat_o, 32'h1111_1111);
      chk($sformatf("bst_m_ack_%0d", b), bus.m_ack_o, 1'b1);
      tick();
    end
    drop();
    settle();
    chk("bst_cyc_fall", bus.s_cyc_o, 4'b0000);
    tick();
    req(32'h2000_0000, 1'b0, 3'b000);
    settle();
    chk("bst_released_idle", bus.s_cyc_o, 4'b0000);
    tick(); settle();
    chk("bst_redecode", bus.s_cyc_o, 4'b0100);
    drop();
    tick();

`ifdef SOC_DECODE_WB_TIMEOUT_EN
    // Watchdog: no ack for 8 strobed cycles
    req(32'h2000_0100, 1'b0, 3'b000);
    tick();
    for (int k = 1; k <= 8; k++) begin
      settle();
      chk($sformatf("wd_wait_stb_%0d", k), bus.s_stb_o, 4'b0100);
      chk($sformatf("wd_wait_err_%0d", k), bus.m_err_o, 1'b0);
      tick();
    end
    settle();
    chk("tmo_s_cyc", bus.s_cyc_o, 4'b0000);
    chk("tmo_m_err", bus.m_err_o, 1'b1);
    chk("tmo_err_valid", err_valid, 1'b1);
    chk("tmo_err_tmo", err_tmo, 1'b1);
    chk("tmo_err_adr", err_adr, 32'h2000_0100);
    drop();
    tick(); settle();
    chk("tmo_pulse_end", bus.m_err_o, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Ack on the limit cycle wins over the timeout
    req(32'h2000_0200, 1'b0, 3'b000);
    tick();
    for (int k = 1; k <= 7; k++) tick();
    bus.s_ack_i[2] = 1'b1;
    settle();
    chk("wd_late_ack", bus.m_ack_o, 1'b1);
    tick(); settle();
    chk("wd_late_no_err", bus.m_err_o, 1'b0);
    chk("wd_late_still_active", bus.s_cyc_o, 4'b0100);
    chk("wd_late_no_capture", err_valid, 1'b0);
    drop();
    tick();
`else
    // Without the watchdog an unresponsive slave is waited on indefinitely
    req(32'h2000_0100, 1'b0, 3'b000);
    tick();
    for (int k = 0; k < 12; k++) tick();
    settle();
    chk("nowd_still_active", bus.s_cyc_o, 4'b0100);
    chk("nowd_no_err", bus.m_err_o, 1'b0);
    chk("nowd_no_capture", err_valid, 1'b0);
    chk("nowd_err_tmo", err_tmo, 1'b0);
    bus.s_ack_i[2] = 1'b1;
    settle();
    chk("nowd_late_ack", bus.m_ack_o, 1'b1);
    drop();
    tick();
`endif

    // Reset in the middle of a burst, with an error capture pending
    req(32'h9000_0000, 1'b0, 3'b000);
    tick();
    drop();
    tick(); settle();
    chk("pre_rst_capture", err_valid, 1'b1);
    req(32'h1000_0000, 1'b0, 3'b010);
    tick();
    bus.s_ack_i[1] = 1'b1;
    settle();
    chk("pre_rst_s_cyc", bus.s_cyc_o, 4'b0010);
    chk("pre_rst_cti", bus.s_cti_o[1], 3'b010);
    rst_n = 1'b0;
    tick(); settle();
    chk("mid_rst_s_cyc", bus.s_cyc_o, 4'b0000);
    chk("mid_rst_s_stb", bus.s_stb_o, 4'b0000);
    chk("mid_rst_m_ack", bus.m_ack_o, 1'b0);
    chk("mid_rst_m_dat", bus.m_dat_o, 32'h0);
    chk("mid_rst_err_valid", err_valid, 1'b0);
    chk("mid_rst_err_adr", err_adr, 32'h0);
    rst_n = 1'b1;
    drop();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_decode_wb_reg.md
Name: soc_decode_wb_reg

Overview:
- Registered, cycle-locked Wishbone address decoder. Routes one master to SLAVES slaves using per-slave base/mask windows.
- Sits between the tile/bus master and the peripheral/memory slaves of the SoC interconnect.
- Adds the following on top of a plain combinational decode:
  - one-cycle registered decode;
  - grant locked for the whole m_cyc_i cycle, including bursts;
  - priority resolution of overlapping windows;
  - built-in error responder for unmapped addresses;
  - sticky error-address capture;
  - optional slave watchdog.

Parameters:
- SLAVES, 4, number of slave ports (1..16)
- DATA_WIDTH, 32, bus data width; multiple of 8
- ADDR_WIDTH, 32, bus address width
- SEL_WIDTH, DATA_WIDTH/8, derived byte-select width (localparam)
- SLAVE_ENABLE, {SLAVES{1'b1}}, per-slave enable bit
- SLAVE_BASE, 0, packed [SLAVES][ADDR_WIDTH] window base
- SLAVE_MASK, 0, packed [SLAVES][ADDR_WIDTH] compare mask; 1 = bit compared
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- m_adr_i/m_dat_i/m_cyc_i/m_stb_i/m_sel_i/m_we_i/m_cti_i/m_bte_i  in  ADDR_WIDTH/DATA_WIDTH/1/1/SEL_WIDTH/1/3/2  master request
- m_dat_o/m_ack_o/m_err_o/m_rty_o  out  DATA_WIDTH/1/1/1  master response
- s_adr_o/s_dat_o/s_cyc_o/s_stb_o/s_sel_o/s_we_o/s_cti_o/s_bte_o  out  [SLAVES] x same widths  slave requests
- s_dat_i/s_ack_i/s_err_i/s_rty_i  in  [SLAVES] x DATA_WIDTH/1/1/1  slave responses
- err_valid_o  out  1  sticky: unmapped access or timeout captured
- err_adr_o  out  ADDR_WIDTH  address of the first captured error
- err_timeout_o  out  1  captured error was a timeout (1) or unmapped (0)
- err_clr_i  in  1  clears the error capture

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is synchronous and active-low.
- Reset values:
  - FSM in IDLE, grant index 0, watchdog counter 0;
  - all s_cyc_o/s_stb_o = 0;
  - m_ack_o/m_err_o/m_rty_o = 0, m_dat_o = 0;
  - err_valid_o = 0, err_adr_o = 0, err_timeout_o = 0.
- Slave pass-through: s_adr/dat/sel/we/cti/bte are broadcast combinationally to every slave.
- Match: match[i] = SLAVE_ENABLE[i] & ((m_adr_i & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i])). The lowest matching index wins; overlap is not an error.
- FSM states: IDLE, ACTIVE, ERR, TMO.
- IDLE:
  - no s_cyc/s_stb; m_* responses are 0.
  - On m_cyc_i & m_stb_i: if any match, register the grant and go to ACTIVE; otherwise go to ERR.
- ACTIVE:
  - s_cyc_o[g] = m_cyc_i and s_stb_o[g] = m_stb_i for the granted slave g only.
  - m_dat/ack/err/rty come combinationally from slave g.
  - The grant is locked until m_cyc_i falls, then return to IDLE in the next cycle.
  - Address changes mid-cycle, including bursts (cti 010) that cross window boundaries, stay with g.
- Latency: the first beat reaches the slave one cycle after the master asserts stb. Later beats are zero-cycle pass-through.
- ERR:
  - m_err_o = 1 for exactly one cycle; m_ack_o = m_rty_o = 0; m_dat_o = 0.
  - Next state is IDLE. If stb is still high there, it is re-decoded, giving one err pulse per 2 cycles.
- Error capture:
  - On entering ERR or TMO with err_valid_o = 0: set err_valid_o, latch m_adr_i into err_adr_o, latch err_timeout_o.
  - Later errors do not overwrite the capture.
  - err_clr_i clears the capture. If err_clr_i and a new error occur in the same cycle, the new error wins.
- Reset mid-transaction: return to IDLE immediately. Slave cyc/stb drop in the cycle after the reset edge; no response is forwarded.

Optional Feature:
- Macro: SOC_DECODE_WB_TIMEOUT_EN.
- With the macro, in ACTIVE:
  - A counter increments each cycle that s_stb_o[g] is high and slave g gives no ack/err/rty. It clears on any response or on leaving ACTIVE.
  - When the count reaches TIMEOUT_CYCLES-1, go to TMO.
- TMO:
  - s_cyc_o/s_stb_o forced to 0; m_err_o = 1 for one cycle; then IDLE.
  - A slave response arriving in the same cycle as the limit wins and no timeout occurs.
- Without the macro: no counter, no TMO state, err_timeout_o is tied to 0, and ACTIVE waits indefinitely.

Decomposition:
- Package soc_decode_wb_pkg holds:
  - enum state_t {IDLE, ACTIVE, ERR, TMO};
  - the function that computes the match vector and priority index;
  - the localparam for the grant index width, $clog2(SLAVES) with a minimum of 1.
- One sub-module, soc_decode_wb_watchdog:
  - counter plus terminal-count flag;
  - instantiated only under SOC_DECODE_WB_TIMEOUT_EN.

Test Plan:
1. Reset and basic read:
   - Stimulus: SLAVES=4; slave 2 at base 0x2000_0000, mask 0xF000_0000. Read 0x2000_0010.
   - Response: s_stb_o[2] one cycle after m_stb_i; m_dat_o = s_dat_i[2] = 0xDEAD_BEEF; m_ack_o with the slave ack; other s_cyc_o stay 0.
2. Unmapped access:
   - Stimulus: write to 0x9000_0000.
   - Response: m_err_o pulses 1 cycle; no s_cyc_o; err_valid_o = 1, err_adr_o = 0x9000_0000, err_timeout_o = 0.
   - A second error leaves err_adr_o unchanged; err_clr_i clears it.
3. Overlap priority:
   - Stimulus: slaves 0 and 1 both match 0x0000_0100.
   - Response: slave 0 granted; no error.
4. Locked 4-beat incrementing burst:
   - Stimulus: cti 010 starting at 0x1FFF_FFF8, crossing into slave 2's window.
   - Response: all 4 beats go to slave 1; grant released 1 cycle after m_cyc_i falls.
5. Timeout (macro on):
   - Stimulus: TIMEOUT_CYCLES=8; slave never acks.
   - Response: TMO reached at the 8th unacked cycle; s_cyc_o drops; m_err_o one pulse; err_timeout_o = 1.
   - An ack arriving on cycle 8 completes normally instead.
6. Reset mid-burst:
   - Stimulus: rst_ni low during ACTIVE.
   - Response: next cycle all outputs are at reset values and the FSM is IDLE.
